// File: rtl/jk_pkg.sv
// jk_pkg: shared FSM state type and J/K excitation codes for the JK drive controller.
package jk_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} jk_state_t;
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;
endpackage

// File: rtl/jk_excite.sv
// jk_excite: per-bit J/K excitation that moves a JK flop from its current Q to a target.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_t,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [1:0] w_code;
        assign w_code = (i_q[b] == i_t[b]) ? JK_HOLD :
                        USE_TOGGLE         ? JK_TOGGLE :
                        i_t[b]             ? JK_SET : JK_RESET;
        assign {o_j[b], o_k[b]} = w_code;
    end
endmodule

// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl: loads a target vector into a JK flop bank by driving J/K for one cycle,
// verifying the fed-back Q and retrying a bounded number of times before flagging an error.
module jk_drive_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_RETRY  = 3,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    jk_state_t        r_state, w_state;
    logic [WIDTH-1:0] r_tgt, w_tgt, w_t, w_ej, w_ek, w_j, w_k, w_mask;
    logic [RW-1:0]    r_retry, w_retry;
    logic             w_done, w_err;

    // One excitation unit serves both the initial drive (fresh target) and retries (held target).
    assign w_t = (r_state == IDLE) ? tgt_data : r_tgt;

    jk_excite #(.WIDTH(WIDTH), .USE_TOGGLE(USE_TOGGLE)) u_excite (
        .i_q(q_fb),
        .i_t(w_t),
        .o_j(w_ej),
        .o_k(w_ek)
    );

    assign tgt_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_state = r_state;
        w_tgt   = r_tgt;
        w_j     = '0;
        w_k     = '0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_mask  = err_mask;
        w_retry = r_retry;
        case (r_state)
            IDLE: if (tgt_valid) begin
                w_tgt   = tgt_data;
                w_j     = w_ej;
                w_k     = w_ek;
                w_retry = '0;
                w_mask  = '0;
                w_state = DRIVE;
            end
            DRIVE: w_state = CHECK;
            CHECK: if (q_fb == r_tgt) begin
                w_done  = 1'b1;
                w_state = IDLE;
            end else if (r_retry < MAX_R) begin
                w_retry = r_retry + 1'b1;
                w_j     = w_ej;
                w_k     = w_ek;
                w_state = DRIVE;
            end else begin
                w_err   = 1'b1;
                w_mask  = q_fb ^ r_tgt;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tgt    <= '0;
            r_retry  <= '0;
            j        <= '0;
            k        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
        end else begin
            r_state  <= w_state;
            r_tgt    <= w_tgt;
            r_retry  <= w_retry;
            j        <= w_j;
            k        <= w_k;
            done     <= w_done;
            err      <= w_err;
            err_mask <= w_mask;
        end
    end
endmodule

// File: tb/tb_jk_drive_ctrl.sv
// tb_jk_drive_ctrl: scoreboard bench driving a set/reset and a toggle-encoded controller
// in lockstep, each closing the loop through a behavioural JK bank with stuck-at injection.
module tb_jk_drive_ctrl;
    localparam int MR = 2;

    typedef struct {
        int               nd;
        logic [3:0][3:0]  jx0, kx0, jx1, kx1;
        bit               ok;
        bit               ab;
        logic [3:0]       mask;
    } txn_t;

    logic       clk = 1'b0, rst_n = 1'b0, tgt_valid = 1'b0;
    logic [3:0] tgt_data = 4'h0;
    logic [3:0] q_fb [2], j [2], k [2], err_mask [2];
    logic       tgt_ready [2], busy [2], done [2], err [2];
    logic [3:0] sm = 4'h0, sv = 4'h0, q_model = 4'h0;
    bit         rst_at_edge = 1'b1, mon_en = 1'b0;
    int         total = 0, bad = 0, last_wait = 0;
    txn_t       exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) rst_at_edge <= !rst_n;

    jk_drive_ctrl #(.WIDTH(4), .MAX_RETRY(MR), .USE_TOGGLE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready[0]),
        .tgt_data(tgt_data), .q_fb(q_fb[0]), .j(j[0]), .k(k[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .err_mask(err_mask[0])
    );

    jk_drive_ctrl #(.WIDTH(4), .MAX_RETRY(MR), .USE_TOGGLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready[1]),
        .tgt_data(tgt_data), .q_fb(q_fb[1]), .j(j[1]), .k(k[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .err_mask(err_mask[1])
    );

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s u%0d: got %0h want %0h at %0t", nm, g, act, want, $time);
        end
    endtask

    // JK bank: Q+ = J&~Q | ~K&Q, stuck bits forced on every update, sync reset to 0
    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic [3:0] r_b;
        always @(posedge clk)
            r_b <= !rst_n ? 4'h0 : ((((j[g] & ~r_b) | (~k[g] & r_b)) & ~sm) | (sv & sm));
        assign q_fb[g] = r_b;
    end

    // Monitor: rebuilds each transfer from busy/j/k/done/err and pops the next expectation
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int         rd = 0, nb = 0;
        bit         act = 1'b0;
        logic [3:0] held = 4'h0;
        logic [3:0] obs_j [4], obs_k [4];
        txn_t       e;
        always @(negedge clk) if (mon_en) begin
            if (rst_at_edge) begin
                if (act) begin
                    chk(g, "exp_avail", rd < exp_q.size(), 1);
                    if (rd < exp_q.size()) chk(g, "abandon", exp_q[rd].ab, 1);
                    rd++;
                    act = 1'b0;
                end
                chk(g, "rst_state", {j[g], k[g], done[g], err[g], busy[g], ~tgt_ready[g], err_mask[g]}, 0);
                held = 4'h0;
            end else if (busy[g]) begin
                if (!act) begin
                    act = 1'b1;
                    nb = 0;
                end
                if (nb % 2 == 0) begin
                    if (nb < 8) begin
                        obs_j[nb/2] = j[g];
                        obs_k[nb/2] = k[g];
                    end
                end else chk(g, "check_jk", {j[g], k[g]}, 0);
                chk(g, "busy_flags", {done[g], err[g], tgt_ready[g]}, 0);
                nb++;
            end else if (act) begin
                act = 1'b0;
                chk(g, "exp_avail", rd < exp_q.size(), 1);
                if (rd < exp_q.size()) begin
                    e = exp_q[rd];
                    rd++;
                    chk(g, "end_kind", e.ab, 0);
                    chk(g, "busy_len", nb, 2 * e.nd);
                    chk(g, "done", done[g], e.ok);
                    chk(g, "err", err[g], !e.ok);
                    chk(g, "err_mask", err_mask[g], e.mask);
                    for (int a = 0; a < e.nd && a < 4; a++) begin
                        chk(g, "drive_j", obs_j[a], g ? e.jx1[a] : e.jx0[a]);
                        chk(g, "drive_k", obs_k[a], g ? e.kx1[a] : e.kx0[a]);
                    end
                    held = e.mask;
                end
            end else begin
                chk(g, "idle", {j[g], k[g], done[g], err[g], ~tgt_ready[g]}, 0);
                chk(g, "mask_hold", err_mask[g], held);
            end
        end
    end

    // Reference: each attempt drives the excitation for (q, t); every non-stuck bit then lands on t
    task automatic predict(input logic [3:0] t, output txn_t e);
        logic [3:0] q, d;
        q = q_model;
        e.nd = 0; e.jx0 = '0; e.kx0 = '0; e.jx1 = '0; e.kx1 = '0; e.ab = 1'b0;
        for (int a = 0; a <= MR; a++) begin
            d = q ^ t;
            e.jx0[a] = d & t;
            e.kx0[a] = d & ~t;
            e.jx1[a] = d;
            e.kx1[a] = d;
            e.nd++;
            q = (t & ~sm) | (sv & sm);
            if (q == t) break;
        end
        e.ok = (q == t);
        e.mask = e.ok ? 4'h0 : (q ^ t);
        q_model = q;
    endtask

    task automatic wait_ready();
        int w;
        tgt_valid = 1'b0;
        w = 0;
        while (!tgt_ready[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk(-1, "ready_wait", tgt_ready[0], 1);
    endtask

    task automatic issue(input logic [3:0] t, input bit hold, input int rdel);
        txn_t e;
        int w;
        if (rdel >= 0) begin
            e.nd = 0; e.jx0 = '0; e.kx0 = '0; e.jx1 = '0; e.kx1 = '0;
            e.ok = 1'b0; e.ab = 1'b1; e.mask = 4'h0;
        end else predict(t, e);
        exp_q.push_back(e);
        tgt_data = t;
        tgt_valid = 1'b1;
        w = 0;
        while (!tgt_ready[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk(-1, "accept_wait", tgt_ready[0], 1);
        last_wait = w;
        @(posedge clk);
        #1;
        if (!hold) tgt_valid = 1'b0;
        if (rdel >= 0) begin
            if (rdel > 0) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            tgt_valid = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            q_model = 4'h0;
            sm = 4'h0;
            sv = 4'h0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, rdel;
        bit hold;
        rst_n = 1'b0;
        tgt_valid = 1'b1;
        tgt_data = 4'hF;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tgt_valid = 1'b0;
        issue(4'b1010, 0, -1);
        issue(4'b0110, 0, -1);
        issue(4'b0101, 0, -1);
        issue(4'b0101, 0, -1);
        issue(4'b0000, 0, -1);
        wait_ready();
        sm = 4'b0001;
        sv = 4'b0000;
        issue(4'b0001, 0, -1);
        wait_ready();
        sm = 4'b0000;
        issue(4'b1111, 0, 0);
        issue(4'b0110, 0, 1);
        wait_ready();
        issue(4'b0011, 1, -1);
        issue(4'b1100, 0, -1);
        chk(-1, "b2b_gap", last_wait, 3);
        wait_ready();
        chk(0, "b2b_bank", q_fb[0], 4'b1100);
        chk(1, "b2b_bank", q_fb[1], 4'b1100);
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                wait_ready();
                sm = 4'(1 << $urandom_range(0, 3));
                sv = q_model & sm;
            end else if (r == 1) begin
                wait_ready();
                sm = 4'h0;
            end
            rdel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
            hold = (rdel < 0) && ($urandom_range(0, 2) == 0);
            issue(4'($urandom), hold, rdel);
            if (!hold) repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_ready();
        repeat (2) @(negedge clk);
        chk(0, "drain", g_mon[0].rd, exp_q.size());
        chk(1, "drain", g_mon[1].rd, exp_q.size());
        chk(0, "bank_end", q_fb[0], q_model);
        chk(1, "bank_end", q_fb[1], q_model);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jk_drive_ctrl.md
# jk_drive_ctrl

Drive controller for a bank of WIDTH JK flip-flops: the write side of the JK excitation interface. It accepts a target state vector over a valid/ready handshake and computes the per-bit J/K excitation from the bank's fed-back Q. It drives J/K for one cycle, then checks that the bank reached the target, retrying a bounded number of times before flagging an error. It sits between control logic that wants to load register states and any JK flop bank whose J/K inputs it owns exclusively.

## Interface
- `WIDTH`, default 4: number of JK flops driven.
- `MAX_RETRY`, default 3: extra drive attempts after a failed check. A value of 0 means a single attempt.
- `USE_TOGGLE`, default 0: selects the encoding for a bit that must change.
  - 0: set (J=1, K=0) or reset (J=0, K=1).
  - 1: toggle (J=1, K=1).
- `clk` in 1: clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `tgt_valid` in 1: a target vector is offered.
- `tgt_ready` out 1: the controller can accept a target.
- `tgt_data` in WIDTH: target Q vector.
- `q_fb` in WIDTH: Q outputs of the flop bank.
- `j` out WIDTH: J drive, registered.
- `k` out WIDTH: K drive, registered.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse; the target was reached.
- `err` out 1: one-cycle pulse; retries were exhausted.
- `err_mask` out WIDTH: `q_fb ^ target` captured at the final failed check.

## Operation
- FSM states are IDLE, DRIVE and CHECK.
  - `tgt_ready` = (state == IDLE).
  - `busy` = (state != IDLE).
- Per-bit excitation `excite(q, t)`:
  - q == t → 00 (hold).
  - q=0, t=1 → 10, or 11 when USE_TOGGLE.
  - q=1, t=0 → 01, or 11 when USE_TOGGLE.
- IDLE: on `tgt_valid & tgt_ready`:
  - capture `tgt_data` into `tgt_q`;
  - `j/k <= excite(q_fb, tgt_data)`;
  - `retry_cnt <= 0`; clear `err_mask`;
  - go to DRIVE.
- IDLE otherwise: `j = k = 0`.
- DRIVE (exactly one cycle): `j/k` are visible and the bank samples them at the closing edge. Then `j/k <= 0` and go to CHECK.
- CHECK: compare `q_fb` with `tgt_q`.
  - Match: `done <= 1`, go to IDLE.
  - Mismatch with `retry_cnt < MAX_RETRY`: `retry_cnt++`, `j/k <= excite(q_fb, tgt_q)`, go to DRIVE.
  - Mismatch with `retry_cnt == MAX_RETRY`: `err <= 1`, `err_mask <= q_fb ^ tgt_q`, go to IDLE.
- `done` and `err` are never high together. Each is high for exactly one cycle.
- `err_mask` holds its value until the next accepted target.
- `retry_cnt` is `$clog2(MAX_RETRY+1)` bits wide (minimum 1) and saturates at MAX_RETRY, never wrapping.
- A target equal to the current Q still takes the full DRIVE/CHECK path, with `j = k = 0`.

## Timing
- Reset, applied when `rst_n` is sampled low at an edge. After that edge:
  - state = IDLE; `j = k = 0`; `done = err = 0`; `err_mask = 0`; `retry_cnt = 0`;
  - hence `tgt_ready = 1` and `busy = 0`.
- `tgt_valid` is ignored while `rst_n` is low.
- Reset mid-transfer (in DRIVE or CHECK) abandons the transfer: `j/k` go to 0 at that edge and no `done`/`err` is produced.
- Latency with an accept at edge E0:
  - `j/k` are valid in cycle E0–E1;
  - CHECK is in E1–E2;
  - `done`/`err` are high in E2–E3, and `tgt_ready` is high in the same cycle.
- Each retry adds 2 cycles.
- Maximum transfer length is 2·(MAX_RETRY+1)+1 cycles including the result cycle.
- Back-to-back: a new target can be accepted at E3, the edge ending the `done` cycle. Throughput is 1 target per 3 cycles with no retries.
- `q_fb` must settle within the same cycle after the bank's clock edge. The bank shares `clk`.

## Structure
- Package `jk_pkg` contains:
  - `jk_state_t` enum (IDLE, DRIVE, CHECK);
  - constants `JK_HOLD` = 2'b00, `JK_RESET` = 2'b01, `JK_SET` = 2'b10, `JK_TOGGLE` = 2'b11.
- Sub-module `jk_excite` is purely combinational: WIDTH-vector `excite()` with a USE_TOGGLE parameter. It is instantiated once and fed `q_fb` plus a mux of `tgt_data`/`tgt_q`.
- The bench includes a behavioural JK bank model (hold/reset/set/toggle, synchronous reset to 0) with a per-bit stuck-at fault injection.

## Test plan
- Test 1, basic set, WIDTH=4, USE_TOGGLE=0:
  - Stimulus: reset, `q_fb = 0000`, send `1010`.
  - Response: `j = 1010`, `k = 0000` for one cycle. `done` is pulsed 3 cycles after accept and `err_mask = 0000`.
- Test 2, toggle encoding, USE_TOGGLE=1:
  - Stimulus: bank at `1010`, send `0110`.
  - Response: `j = k = 1100`. The bank reads `0110` in CHECK and `done` pulses.
- Test 3, no-change target:
  - Stimulus: bank at `0101`, send `0101`.
  - Response: `j = k = 0000`, `done` 3 cycles after accept, `busy` high for 2 cycles.
- Test 4, exhausted retries, MAX_RETRY=2:
  - Stimulus: bit0 stuck at 0, send `0001`.
  - Response: three DRIVE cycles with `j = 0001`. `err` pulses at cycle 7 after accept, `err_mask = 0001`, and `done` is never asserted.
- Test 5, reset mid-transfer:
  - Stimulus: `rst_n` low during DRIVE.
  - Response: next cycle `j = k = 0`, `busy = 0`, `tgt_ready = 1`, and no `done`/`err`.
- Test 6, back-to-back:
  - Stimulus: `tgt_valid` held with `0011` then `1100`.
  - Response: second accept happens at the edge ending the first `done` cycle. Two `done` pulses, 3 cycles apart, and the bank ends at `1100`.
